// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared widths and FSM state encoding for the D-mem responder slice.
//   DM_AW / DM_DW / DM_MW : address, data and byte-mask widths of the dm_req/dm_resp interface.
//   dmr_state_e           : responder FSM states. The FSM exists only when DMEM_WAIT_EN is defined.
package dmem_responder_pkg;

  localparam int unsigned DM_AW = 64;
  localparam int unsigned DM_DW = 64;
  localparam int unsigned DM_MW = 8;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_e;

endpackage

// File: rtl/dmem_responder_sram_1rw.sv
// dmem_sram_1rw
//   Single-port DEPTH x 64-bit data RAM with per-byte write enables and a
//   registered read port. One read or one write per cycle.
//   Ports:
//     clk    in   core clock
//     en     in   access enable for this cycle
//     we     in   1 = write, 0 = read (qualified by en)
//     wmask  in   byte enables for writes
//     addr   in   word index
//     wdata  in   write data
//     rdata  out  read data, valid the cycle after a read; holds its value
//                 until the next read so it doubles as the read-data capture
//   The array has no reset; contents survive rst_n.
module dmem_sram_1rw
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [DM_MW-1:0] wmask,
  input  logic [AW-1:0]    addr,
  input  logic [DM_DW-1:0] wdata,
  output logic [DM_DW-1:0] rdata
);

  logic [DM_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(DM_MW); i++) begin
          if (wmask[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory end of the D-mem request/response interface (core TCM). Accepts one
//   dm_req beat, performs a byte-masked store or a full-word load on the local
//   SRAM and returns exactly one dm_resp beat per accepted request.
//   Ports:
//     clk, rst_n     core clock, asynchronous active-low reset
//     dm_req_*       request beat (addr, wdata, wmask, wen, valid) and ready
//     dm_resp_rdata  loaded word; 0 for stores and out-of-range accesses
//     dm_resp_valid  one-cycle response pulse, no backpressure
//     dm_resp_err    address outside [BASE_ADDR, BASE_ADDR + DEPTH*8)
//   Build option:
//     DMEM_WAIT_EN   when defined, an IDLE -> WAIT -> RESP FSM adds WAIT_CYCLES
//                    of response latency and allows one outstanding request.
//                    When undefined, ready is high every cycle after reset and
//                    the response follows the accepting edge directly.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned      DEPTH       = 1024,
  parameter logic [DM_AW-1:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned      WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DM_AW-1:0] dm_req_addr,
  input  logic [DM_DW-1:0] dm_req_wdata,
  input  logic [DM_MW-1:0] dm_req_wmask,
  input  logic             dm_req_wen,
  input  logic             dm_req_valid,
  output logic             dm_req_ready,
  output logic [DM_DW-1:0] dm_resp_rdata,
  output logic             dm_resp_valid,
  output logic             dm_resp_err
);

  localparam int unsigned      IW   = $clog2(DEPTH);
  localparam logic [DM_AW-1:0] SPAN = DM_AW'(DEPTH) << 3;

  // Offset arithmetic wraps for addresses below BASE_ADDR, so a single
  // unsigned compare against the window size covers both ends.
  function automatic logic in_window(input logic [DM_AW-1:0] off);
    return off < SPAN;
  endfunction

  logic [DM_AW-1:0] off_p0;
  logic             in_range_p0;
  logic             accept_p0;
  logic [IW-1:0]    idx_p0;
  logic [DM_DW-1:0] sram_rdata;
  logic             run_q;
  logic             load_p1;
  logic             err_p1;
  logic             resp_vld;

  // ---- stage p0: request decode and SRAM access ----
  assign off_p0      = dm_req_addr - BASE_ADDR;
  assign in_range_p0 = in_window(off_p0);
  assign idx_p0      = off_p0[IW+2:3];
  assign accept_p0   = dm_req_valid && dm_req_ready;

  dmem_sram_1rw #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_sram (
    .clk   (clk),
    .en    (accept_p0 && in_range_p0),
    .we    (dm_req_wen),
    .wmask (dm_req_wmask),
    .addr  (idx_p0),
    .wdata (dm_req_wdata),
    .rdata (sram_rdata)
  );

  // Ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // ---- stage p1: latched request attributes for the response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else if (accept_p0) begin
      load_p1 <= !dm_req_wen;
      err_p1  <= !in_range_p0;
    end
  end

`ifdef DMEM_WAIT_EN
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  dmr_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMR_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMR_IDLE: begin
        if (accept_p0) begin
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES == 0) ? DMR_RESP : DMR_WAIT;
        end
      end
      DMR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DMR_RESP;
        end
      end
      DMR_RESP: state_d = DMR_IDLE;
      default:  state_d = DMR_IDLE;
    endcase
  end

  assign dm_req_ready = run_q && (state_q == DMR_IDLE);
  assign resp_vld     = (state_q == DMR_RESP);
`else
  logic vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
    end
  end

  assign dm_req_ready = run_q;
  assign resp_vld     = vld_p1;
`endif

  // The SRAM read register only changes on a read, so the word captured at
  // access time is still present when the response goes out.
  assign dm_resp_valid = resp_vld;
  assign dm_resp_err   = resp_vld && err_p1;
  assign dm_resp_rdata = (resp_vld && load_p1 && !err_p1) ? sram_rdata : '0;

endmodule
